mpadder_pipe: RTL and testbench

//  Parametrised two-stage carry-select multi-precision adder/subtractor with valid/ready handshake.

---
 rtl/mpadder_pipe.sv | 124 ++++++++++++
 tb/tb_mpadder_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpadder_pipe.sv
// Two-stage carry-select add/sub: stage 1 forms per-block dual sums, stage 2 resolves the select chain.
// Latency 2 cycles, 1 op/cycle; out_valid & ~out_ready holds the result while stage 1 keeps at most one more op.
module mpadder_pipe #(
  parameter int WIDTH = 1027,
  parameter int BLOCK = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NB = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int LW = WIDTH - (NB - 1) * BLOCK;

  logic             s1_valid;
  logic             s1_sub;
  logic [TAG_W-1:0] s1_tag;
  logic             adv2;
  logic             accept;
  logic [WIDTH-1:0] res_sum;
  logic [NB:1]      carry;

  assign adv2     = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | adv2;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sub   <= 1'b0;
      s1_tag   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sub   <= in_sub;
      s1_tag   <= in_tag;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_blk
    localparam int BW = (g == NB - 1) ? LW : BLOCK;
    logic [BW-1:0] a_blk;
    logic [BW-1:0] b_blk;

    assign a_blk = in_a[g*BLOCK +: BW];
    assign b_blk = in_b[g*BLOCK +: BW] ^ {BW{in_sub}};

    if (g == 0) begin : g_lsb
      // The subtract +1 enters here, so only the true sum is needed.
      logic [BW:0]   t;
      logic [BW-1:0] sum_q;
      logic          c_q;

      assign t = {1'b0, a_blk} + {1'b0, b_blk} + {{BW{1'b0}}, in_sub};

      always_ff @(posedge clk) begin
        if (reset) begin
          sum_q <= '0;
          c_q   <= 1'b0;
        end else if (accept) begin
          sum_q <= t[BW-1:0];
          c_q   <= t[BW];
        end
      end

      assign res_sum[BW-1:0] = sum_q;
      assign carry[1]        = c_q;
    end else begin : g_sel
      logic [BW:0]   t0;
      logic [BW:0]   t1;
      logic [BW-1:0] sum0_q;
      logic [BW-1:0] sum1_q;
      logic          c0_q;
      logic          c1_q;

      assign t0 = {1'b0, a_blk} + {1'b0, b_blk};
      assign t1 = {1'b0, a_blk} + {1'b0, b_blk} + {{BW{1'b0}}, 1'b1};

      always_ff @(posedge clk) begin
        if (reset) begin
          sum0_q <= '0;
          sum1_q <= '0;
          c0_q   <= 1'b0;
          c1_q   <= 1'b0;
        end else if (accept) begin
          sum0_q <= t0[BW-1:0];
          sum1_q <= t1[BW-1:0];
          c0_q   <= t0[BW];
          c1_q   <= t1[BW];
        end
      end

      assign res_sum[g*BLOCK +: BW] = carry[g] ? sum1_q : sum0_q;
      assign carry[g+1]             = carry[g] ? c1_q : c0_q;
    end
  end

  // For subtraction a carry-out means no borrow, hence the xor with sub.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (adv2) begin
      out_valid  <= 1'b1;
      out_result <= {s1_sub ^ carry[NB], res_sum};
      out_tag    <= s1_tag;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mpadder_pipe.sv
// Bench for mpadder_pipe: default-width instance with a queue-based arithmetic model,
// plus two small instances for the 8/4 and 130/64 directed cases.
module tb_mpadder_pipe;
  localparam int W  = 1027;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag, out_tag;
  logic [W:0]    out_result;

  logic          s_valid, s_ready, s_sub, s_ovalid;
  logic [7:0]    s_a, s_b;
  logic [TW-1:0] s_tag, s_otag;
  logic [8:0]    s_result;

  logic          t_valid, t_ready, t_sub, t_ovalid;
  logic [129:0]  t_a, t_b;
  logic [TW-1:0] t_tag, t_otag;
  logic [130:0]  t_result;

  mpadder_pipe #(.WIDTH(W), .BLOCK(64), .TAG_W(TW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag));

  mpadder_pipe #(.WIDTH(8), .BLOCK(4), .TAG_W(TW)) u_small (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s_ready), .in_sub(s_sub),
    .in_a(s_a), .in_b(s_b), .in_tag(s_tag), .out_valid(s_ovalid), .out_ready(1'b1),
    .out_result(s_result), .out_tag(s_otag));

  mpadder_pipe #(.WIDTH(130), .BLOCK(64), .TAG_W(TW)) u_top2 (
    .clk(clk), .reset(reset), .in_valid(t_valid), .in_ready(t_ready), .in_sub(t_sub),
    .in_a(t_a), .in_b(t_b), .in_tag(t_tag), .out_valid(t_ovalid), .out_ready(1'b1),
    .out_result(t_result), .out_tag(t_otag));

  typedef struct packed {
    logic [W:0]    r;
    logic [TW-1:0] t;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   n_out = 0;
  int   stall_cnt = 0;

  // Prints the lowest 64-bit window where the two values differ.
  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    logic [W+64:0] g, e, d;
    int idx;
    total++;
    if (got !== exp) begin
      bad++;
      g = {64'b0, got};
      e = {64'b0, exp};
      d = g ^ e;
      idx = 0;
      for (int i = W; i >= 0; i--) if (d[i] !== 1'b0) idx = i;
      idx = (idx / 64) * 64;
      $display("FAIL %s bits[%0d+:64] got=%h exp=%h", tag, idx, g[idx +: 64], e[idx +: 64]);
    end
  endtask

  function automatic logic [W:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    return sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W+31:0] v;
    v = '0;
    case ($urandom_range(0, 7))
      0: v = {32'b0, {W{1'b1}}};
      1: v = '0;
      2: v[31:0] = $urandom();
      default: for (int i = 0; i < W; i += 32) v[i +: 32] = $urandom();
    endcase
    return v[W-1:0];
  endfunction

  // Output side of the default instance is checked every cycle against the model queue.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("stale_valid", {{W{1'b0}}, out_valid}, '0);
        end else begin
          check("result", out_result, q[0].r);
          check("tag", {{(W+1-TW){1'b0}}, out_tag}, {{(W+1-TW){1'b0}}, q[0].t});
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back('{r: ref_res(in_a, in_b, in_sub), t: in_tag});
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic [TW-1:0] tag);
    int n;
    in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stall_cnt++;
      n++;
      if (n > 50) begin
        check("send_wait", {{W{1'b0}}, in_ready}, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  logic [W-1:0] x;
  logic [W-1:0] bp_a[3];
  logic [W-1:0] bp_b[3];
  int acc, base, lim;

  initial begin
    reset = 1'b1; out_ready = 1'b1;
    in_valid = 0; in_sub = 0; in_a = '0; in_b = '0; in_tag = '0;
    s_valid = 0; s_sub = 0; s_a = '0; s_b = '0; s_tag = '0;
    t_valid = 0; t_sub = 0; t_a = '0; t_b = '0; t_tag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {{W{1'b0}}, out_valid}, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", {{(W+1-TW){1'b0}}, out_tag}, 0);
    check("rst_in_ready", {{W{1'b0}}, in_ready}, 1);

    // Small instances: latency and boundary arithmetic
    @(posedge clk); #1;
    s_valid = 1; s_a = 8'hFF; s_b = 8'h01; s_sub = 0; s_tag = 4'd3;
    t_valid = 1; t_a = 130'b1 << 129; t_b = 130'b1 << 129; t_sub = 0; t_tag = 4'd5;
    @(negedge clk);
    check("s_in_ready", {{W{1'b0}}, s_ready}, 1);
    @(posedge clk); #1;
    s_a = 8'h00; s_b = 8'h01; s_sub = 1; s_tag = 4'd6;
    t_a = '0; t_b = 130'd1; t_sub = 1; t_tag = 4'd7;
    @(negedge clk);
    check("s_lat_not_yet", {{W{1'b0}}, s_ovalid}, 0);
    @(posedge clk); #1;
    s_valid = 0; t_valid = 0;
    @(negedge clk);
    check("s_lat_valid", {{W{1'b0}}, s_ovalid}, 1);
    check("s_add_ff_1", {{(W-8){1'b0}}, s_result}, 'h100);
    check("s_add_tag", {{(W+1-TW){1'b0}}, s_otag}, 3);
    check("t_add_2p129", {{(W-130){1'b0}}, t_result}, {{(W-130){1'b0}}, 131'b1 << 130});
    check("t_add_tag", {{(W+1-TW){1'b0}}, t_otag}, 5);
    @(posedge clk); #1;
    @(negedge clk);
    check("s_sub_0_1", {{(W-8){1'b0}}, s_result}, 'h1FF);
    check("s_sub_tag", {{(W+1-TW){1'b0}}, s_otag}, 6);
    check("t_sub_0_1", {{(W-130){1'b0}}, t_result}, {{(W-130){1'b0}}, {131{1'b1}}});
    check("t_sub_tag", {{(W+1-TW){1'b0}}, t_otag}, 7);
    @(posedge clk); #1;
    @(negedge clk);
    check("s_idle", {{W{1'b0}}, s_ovalid}, 0);
    @(posedge clk); #1;

    // Full-width carry ripple and a-a
    send({W{1'b1}}, 1, 1'b0, 4'd1);
    x = rnd_op();
    send(x, x, 1'b1, 4'd2);
    drain();

    // Back-to-back random stream
    stall_cnt = 0;
    base = n_out;
    for (int i = 0; i < 100; i++) send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 4'(i));
    drain();
    check("stream_stalls", stall_cnt, 0);
    check("stream_count", n_out - base, 100);

    // Backpressure: three ops offered while the consumer stalls
    base = n_out;
    for (int i = 0; i < 3; i++) begin bp_a[i] = rnd_op(); bp_b[i] = rnd_op(); end
    out_ready = 0;
    acc = 0;
    in_a = bp_a[0]; in_b = bp_b[0]; in_sub = 0; in_tag = 4'd10; in_valid = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      if (acc < 3) begin
        in_a = bp_a[acc]; in_b = bp_b[acc]; in_sub = acc[0]; in_tag = 4'(10 + acc);
      end else in_valid = 0;
    end
    @(negedge clk);
    check("bp_accepted", acc, 2);
    check("bp_in_ready", {{W{1'b0}}, in_ready}, 0);
    @(posedge clk); #1;
    out_ready = 1;
    lim = 0;
    while (acc < 3 && lim < 20) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      lim++;
    end
    in_valid = 0;
    drain();
    check("bp_count", n_out - base, 3);

    // Reset with both stages full: nothing in flight may emerge
    out_ready = 0;
    send(rnd_op(), rnd_op(), 1'b0, 4'd4);
    send(rnd_op(), rnd_op(), 1'b1, 4'd5);
    in_a = rnd_op(); in_b = rnd_op(); in_tag = 4'd6; in_valid = 1;
    @(negedge clk);
    check("full_in_ready", {{W{1'b0}}, in_ready}, 0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; in_valid = 0; out_ready = 1;
    base = n_out;
    @(negedge clk);
    check("rst2_out_valid", {{W{1'b0}}, out_valid}, 0);
    check("rst2_out_result", out_result, 0);
    check("rst2_in_ready", {{W{1'b0}}, in_ready}, 1);
    repeat (6) @(posedge clk);
    #1;
    check("rst2_no_emit", n_out - base, 0);
    send(rnd_op(), rnd_op(), 1'b1, 4'd9);
    drain();
    check("rst2_recover", n_out - base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
